// File: rtl/core_bus_arbiter_if.sv
// Signal bundle between the core-side requesters, the arbiter and the Wishbone slave.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface core_bus_arbiter_if #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_LEN    = 32,
    parameter int WB_DATA_LEN = 32,
    parameter int TAG_WIDTH   = 4
);
    logic [NUM_CH-1:0]                 req_valid_i;
    logic [NUM_CH-1:0]                 req_ready_o;
    logic [NUM_CH-1:0]                 req_we_i;
    logic [NUM_CH*ADDR_LEN-1:0]        req_addr_i;
    logic [NUM_CH*WB_DATA_LEN-1:0]     req_data_i;
    logic [NUM_CH*WB_DATA_LEN/8-1:0]   req_sel_i;
    logic [NUM_CH*TAG_WIDTH-1:0]       req_tag_i;
    logic [NUM_CH-1:0]                 resp_valid_o;
    logic [NUM_CH-1:0]                 resp_ready_i;
    logic [WB_DATA_LEN-1:0]            resp_data_o;
    logic [TAG_WIDTH-1:0]              resp_tag_o;
    logic                              resp_err_o;
    logic                              wb_cyc_o;
    logic                              wb_stb_o;
    logic                              wb_we_o;
    logic [ADDR_LEN-1:0]               wb_adr_o;
    logic [WB_DATA_LEN-1:0]            wb_dat_o;
    logic [WB_DATA_LEN/8-1:0]          wb_sel_o;
    logic                              wb_ack_i;
    logic                              wb_err_i;
    logic [WB_DATA_LEN-1:0]            wb_dat_i;
    logic                              busy_o;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i, req_sel_i, req_tag_i,
        input  resp_ready_i, wb_ack_i, wb_err_i, wb_dat_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, busy_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_data_i, req_sel_i, req_tag_i,
        output resp_ready_i, wb_ack_i, wb_err_i, wb_dat_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, busy_o
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// N-channel request/response arbiter onto one Wishbone classic master, with
// round-robin or fixed priority, bus-error reporting and a bus-hang timeout.
module core_bus_arbiter #(
    parameter int NUM_CH         = 3,
    parameter int ADDR_LEN       = 32,
    parameter int WB_DATA_LEN    = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PRIO_MODE      = 0
) (
    input logic                clk,
    input logic                reset,
    core_bus_arbiter_if.master bus
);
    localparam int SEL_LEN = WB_DATA_LEN / 8;
    localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t              state;
    logic [PTR_W-1:0]    grant;
    logic [PTR_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                we_q;
    logic [ADDR_LEN-1:0] adr_q;
    logic [WB_DATA_LEN-1:0] dat_q;
    logic [SEL_LEN-1:0]  sel_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                cyc_q;
    logic [NUM_CH-1:0]   resp_valid_q;
    logic [WB_DATA_LEN-1:0] resp_data_q;
    logic                resp_err_q;

    logic [PTR_W-1:0]    pick;
    logic                pick_ok;
    logic [NUM_CH-1:0]   req_ready;
    logic                tmo_fire;

    // Search order starts at rr_ptr in round-robin mode, at channel 0 in fixed mode.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_w;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (PRIO_MODE != 0) ? k : int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_w = PTR_W'(idx);
            if (!pick_ok && bus.req_valid_i[idx_w]) begin
                pick    = idx_w;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && pick_ok && !reset) req_ready[pick] = 1'b1;
    end

    assign tmo_fire = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            tmo_cnt      <= '0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            tag_q        <= '0;
            cyc_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant   <= pick;
                        we_q    <= bus.req_we_i[pick];
                        adr_q   <= bus.req_addr_i[int'(pick)*ADDR_LEN +: ADDR_LEN];
                        dat_q   <= bus.req_data_i[int'(pick)*WB_DATA_LEN +: WB_DATA_LEN];
                        sel_q   <= bus.req_sel_i[int'(pick)*SEL_LEN +: SEL_LEN];
                        tag_q   <= bus.req_tag_i[int'(pick)*TAG_WIDTH +: TAG_WIDTH];
                        tmo_cnt <= '0;
                        cyc_q   <= 1'b1;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus.wb_err_i || bus.wb_ack_i || tmo_fire) begin
                        // err beats ack, ack beats a timeout firing in the same cycle
                        cyc_q        <= 1'b0;
                        resp_valid_q <= NUM_CH'(1) << grant;
                        resp_err_q   <= bus.wb_err_i || !bus.wb_ack_i;
                        resp_data_q  <= (!bus.wb_err_i && bus.wb_ack_i) ? bus.wb_dat_i : '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready_i[grant]) begin
                        resp_valid_q <= '0;
                        state        <= IDLE;
                        if (PRIO_MODE == 0) begin
                            rr_ptr <= (grant == PTR_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.resp_tag_o   = tag_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.wb_cyc_o     = cyc_q;
    assign bus.wb_stb_o     = cyc_q;
    assign bus.wb_we_o      = we_q;
    assign bus.wb_adr_o     = adr_q;
    assign bus.wb_dat_o     = dat_q;
    assign bus.wb_sel_o     = sel_q;
    assign bus.busy_o       = (state != IDLE);
endmodule
